// File: rtl/tlp_dw_fifo_pkg.sv
// rtl/tlp_dw_fifo_pkg.sv - shared TLP constants for the DW FIFO
package tlp_dw_fifo_pkg;

  localparam int TLP_DW_WIDTH = 32;

endpackage

// File: rtl/tlp_dw_fifo_if.sv
// rtl/tlp_dw_fifo_if.sv - write/read handshake and status bundle for the DW FIFO
interface tlp_dw_fifo_if
  import tlp_dw_fifo_pkg::*;
#(
  parameter int WIDTH = TLP_DW_WIDTH,
  parameter int AW    = 4
);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/tlp_dw_fifo_up_down_counter.sv
// rtl/tlp_dw_fifo_up_down_counter.sv - enable/direction occupancy counter
module up_down_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/tlp_dw_fifo.sv
// rtl/tlp_dw_fifo.sv - single-clock DW FIFO with registered read and sticky error flags
module tlp_dw_fifo
  import tlp_dw_fifo_pkg::*;
#(
  parameter int WIDTH = TLP_DW_WIDTH,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  tlp_dw_fifo_if.slave  fifo
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;

  // Status comes only from the registered occupancy so it never glitches with requests
  assign full   = (occ == (AW+1)'(DEPTH));
  assign empty  = (occ == '0);
  assign wr_acc = fifo.wr_en & ~full;
  assign rd_acc = fifo.rd_en & ~empty;

  up_down_counter #(
    .WIDTH (AW + 1)
  ) u_occ (
    .clk   (clk),
    .reset (reset),
    .en    (wr_acc ^ rd_acc),
    .up    (wr_acc),
    .count (occ)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= fifo.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (fifo.wr_en && full) begin
        overflow_q <= 1'b1;
      end
      if (fifo.rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign fifo.rd_data   = rd_data_q;
  assign fifo.rd_valid  = rd_valid_q;
  assign fifo.full      = full;
  assign fifo.empty     = empty;
  assign fifo.count     = occ;
  assign fifo.overflow  = overflow_q;
  assign fifo.underflow = underflow_q;

endmodule

// File: tb/tb_tlp_dw_fifo.sv
// tb/tb_tlp_dw_fifo.sv - directed scoreboard bench for tlp_dw_fifo
module tb_tlp_dw_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int passed = 0;
  int total  = 0;

  logic [31:0] sb[$];
  int          m_count;
  logic [31:0] m_rd_data;
  logic        m_over;
  logic        m_under;

  tlp_dw_fifo_if #(.WIDTH(32), .AW(4)) bus ();

  tlp_dw_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH),
    .AW    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 64'(bus.count), 64'(m_count));
    check({tag, ".full"}, 64'(bus.full), 64'(m_count == DEPTH));
    check({tag, ".empty"}, 64'(bus.empty), 64'(m_count == 0));
    check({tag, ".overflow"}, 64'(bus.overflow), 64'(m_over));
    check({tag, ".underflow"}, 64'(bus.underflow), 64'(m_under));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".count"}, 64'(bus.count), 64'(0));
    check({tag, ".empty"}, 64'(bus.empty), 64'(1));
    check({tag, ".full"}, 64'(bus.full), 64'(0));
    check({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'(0));
    check({tag, ".rd_data"}, 64'(bus.rd_data), 64'(0));
    check({tag, ".overflow"}, 64'(bus.overflow), 64'(0));
    check({tag, ".underflow"}, 64'(bus.underflow), 64'(0));
  endtask

  // One clock of stimulus: applied after a falling edge, judged on the next falling edge
  task automatic step(input string tag, input logic we, input logic [31:0] wd, input logic re);
    logic wacc;
    logic racc;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    wacc = we && (m_count != DEPTH);
    racc = re && (m_count != 0);
    if (we && m_count == DEPTH) m_over = 1'b1;
    if (re && m_count == 0) m_under = 1'b1;
    if (racc) m_rd_data = sb.pop_front();
    if (wacc) sb.push_back(wd);
    m_count = m_count + int'(wacc) - int'(racc);
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'(racc));
    check({tag, ".rd_data"}, 64'(bus.rd_data), 64'(m_rd_data));
    check_status(tag);
  endtask

  task automatic model_reset();
    sb.delete();
    m_count   = 0;
    m_rd_data = '0;
    m_over    = 1'b0;
    m_under   = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    model_reset();

    #12;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 32'(i), 1'b0);
    step("wr_full", 1'b1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 32'h0, 1'b1);
    step("rd_empty", 1'b0, 32'h0, 1'b1);
    step("wr_rd_empty", 1'b1, 32'h0000A5A5, 1'b1);

    for (int i = 0; i < 4; i++) step("to5", 1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) step("simul", 1'b1, 32'h200 + 32'(i), 1'b1);
    for (int i = 0; i < 4; i++) step("to9", 1'b1, 32'h300 + 32'(i), 1'b0);

    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("mid_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) step("refill", 1'b1, 32'h400 + 32'(i), 1'b0);
    step("wr_rd_full", 1'b1, 32'hCAFEF00D, 1'b1);
    for (int i = 0; i < 15; i++) step("final_drain", 1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tlp_dw_fifo.md
TLP_DW_FIFO -- requirements
Module: tlp_dw_fifo

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data word width in bits (one TLP DW).
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count; it SHALL be a power of two, at least 2.
REQ-003 Parameter AW, default 4, SHALL equal log2(DEPTH) and size the pointers.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 wr_en  input  1  SHALL be the write request.
REQ-007 wr_data  input  WIDTH  SHALL be the write data.
REQ-008 rd_en  input  1  SHALL be the read request.
REQ-009 rd_data  output  WIDTH  SHALL be the registered read data.
REQ-010 rd_valid  output  1  SHALL flag that rd_data holds a popped word.
REQ-011 full  output  1  SHALL assert when count equals DEPTH.
REQ-012 empty  output  1  SHALL assert when count equals 0.
REQ-013 count  output  AW+1  SHALL give the current occupancy, 0..DEPTH.
REQ-014 overflow  output  1  SHALL be a sticky flag for a write attempted while full.
REQ-015 underflow  output  1  SHALL be a sticky flag for a read attempted while empty.

Function
REQ-016 A write SHALL be accepted iff wr_en=1 and full=0; the block SHALL store wr_data at wr_ptr and increment wr_ptr.
REQ-017 A read SHALL be accepted iff rd_en=1 and empty=0; the block SHALL register mem[rd_ptr] into rd_data and increment rd_ptr.
REQ-018 Read latency SHALL be 1 cycle: rd_valid=1 in the cycle after an accepted read, and 0 otherwise.
REQ-019 rd_data SHALL hold its last value when no read is accepted.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-021 A write alone SHALL raise count by 1.
REQ-022 A read alone SHALL lower count by 1.
REQ-023 When a write and a read are both accepted in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 full and empty SHALL be decoded from the registered count, never from the request inputs.
REQ-025 Write when full: the data SHALL be dropped, no state SHALL change, and overflow SHALL be set to 1.
REQ-026 Read when empty: no state SHALL change, rd_valid SHALL be 0, and underflow SHALL be set to 1.
REQ-027 When full, a simultaneous wr_en and rd_en SHALL accept only the read, and overflow SHALL be set.
REQ-028 When empty, a simultaneous wr_en and rd_en SHALL accept only the write, and underflow SHALL be set; there SHALL be no write-through.
REQ-029 overflow and underflow SHALL clear only on reset.
REQ-030 Occupancy counter control SHALL be enable = wr_acc XOR rd_acc, up = wr_acc.

Reset
REQ-031 While reset=0, the block SHALL force: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-032 An asserted reset SHALL take effect immediately, without waiting for a clock edge.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries.
REQ-034 The storage array SHALL NOT be reset.
REQ-035 The first accepted operation after reset SHALL occur on the first rising edge with reset=1.

Structure
REQ-036 Occupancy SHALL be held in one instance of the existing up_down_counter sub-module, with WIDTH=AW+1, driven per REQ-030.
REQ-037 The TLP DW width constant (32) SHALL live in the shared TLP package, and WIDTH SHALL default from it.
REQ-038 Storage SHALL be an inferred register array of DEPTH x WIDTH; no vendor primitives.

Verification (DEPTH=16, WIDTH=32)
REQ-039 Reset, then write 0x00000001..0x00000010 in 16 cycles -> count=16, full=1, empty=0, overflow=0.
REQ-040 From full, write 0xDEADBEEF -> overflow=1, count stays 16; then 16 reads -> rd_data 0x1..0x10 in order, each rd_valid=1 one cycle after the read, then empty=1.
REQ-041 From empty, rd_en=1 for 1 cycle -> rd_valid=0, underflow=1, count=0.
REQ-042 With count=5, 20 cycles of simultaneous wr_en and rd_en -> count stays 5, data stays FIFO-ordered, and both pointers wrap past 15.
REQ-043 With count=9, pulse reset low mid-cycle -> all outputs reach reset values before the next edge; count=0, empty=1.
REQ-044 From full, simultaneous wr_en and rd_en -> count=15, overflow=1, and the popped word is the oldest entry.
